// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Handshake: a byte moves on a rising clk edge with in_valid && in_ready; in_data must stay stable while in_valid is high and in_ready is low.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian program image into instruction memory and holds the core until done.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  imem_loader_if.master   bus,
  output logic            core_hold,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] words_loaded,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_CHK  = 3'd3,
    S_DATA = 3'd4,
    S_CSUM = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  localparam logic [LEN_W-1:0]  CAPACITY = LEN_W'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]   WORD_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t           state_q;
  state_t           state_d;
  logic             ready_d;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       byte_cnt_q;
  logic [23:0]      word_buf_q;
  logic [ADDR_W:0]  n_words;
  logic             accept;
  logic             start_load;
  logic             last_byte;

  assign accept     = bus.in_valid && bus.in_ready;
  assign start_load = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  // Only meaningful in DATA, where the length has already passed the capacity check.
  assign n_words    = len_q[ADDR_W:0];
  assign last_byte  = (state_q == S_DATA) && accept && (byte_cnt_q == 2'd3) &&
                      (words_loaded == n_words - WORD_ONE);
  assign state_dbg  = state_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       csum_ok;

  assign csum_ok = (bus.in_data == csum_q);

  always_ff @(posedge clk) begin
    if (reset || start_load) begin
      csum_q <= '0;
    end else if (state_q == S_DATA && accept) begin
      csum_q <= csum_q ^ bus.in_data;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN0;
      S_LEN0: if (accept) state_d = S_LEN1;
      S_LEN1: if (accept) state_d = S_CHK;
      S_CHK: begin
        if (len_q == '0) begin
          state_d = S_TAIL;
        end else if (len_q > CAPACITY) begin
          state_d = S_ERR;
        end else begin
          state_d = S_DATA;
        end
      end
      // Leave DATA on the edge that ends the write cycle of the final word.
      S_DATA: if (bus.imem_we && words_loaded == n_words) state_d = S_TAIL;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: if (accept) state_d = csum_ok ? S_DONE : S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    case (state_d)
      S_LEN0, S_LEN1, S_CSUM: ready_d = 1'b1;
      S_DATA:                 ready_d = !last_byte && (words_loaded != n_words);
      default:                ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      core_hold      <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      words_loaded   <= '0;
      len_q          <= '0;
      byte_cnt_q     <= '0;
      word_buf_q     <= '0;
    end else begin
      state_q      <= state_d;
      bus.in_ready <= ready_d;
      core_hold    <= (state_d != S_DONE);
      done         <= (state_d == S_DONE);
      error        <= (state_d == S_ERR);
      bus.imem_we  <= 1'b0;

      if (start_load) begin
        words_loaded <= '0;
        byte_cnt_q   <= '0;
      end

      if (state_q == S_LEN0 && accept) len_q[7:0] <= bus.in_data;
      if (state_q == S_LEN1 && accept) len_q[LEN_W-1 -: 8] <= bus.in_data;

      if (state_q == S_DATA && accept) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        case (byte_cnt_q)
          2'd0: word_buf_q[7:0]   <= bus.in_data;
          2'd1: word_buf_q[15:8]  <= bus.in_data;
          2'd2: word_buf_q[23:16] <= bus.in_data;
          default: begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= words_loaded[ADDR_W-1:0];
            bus.imem_wdata <= {bus.in_data, word_buf_q};
            words_loaded   <= words_loaded + WORD_ONE;
          end
        endcase
      end
    end
  end

endmodule
